// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - parametrised synchronous FIFO with level, threshold and sticky error flags
//
// Purpose: byte-oriented FIFO between the UART/command front-end and its
// consumers. It provides programmable almost-full/almost-empty thresholds,
// a level output, sticky overflow/underflow flags, a synchronous flush, and
// either show-ahead (FWFT=1) or registered (FWFT=0) read data.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   flush         synchronous clear of contents (pointers, level, data_valid)
//   write_en      write request; accepted when not full
//   data_in       write data
//   read_en       read request; accepted when not empty
//   data_out      read data (show-ahead or registered, see FWFT)
//   data_valid    data_out holds a valid word
//   full          level == DEPTH
//   empty         level == 0
//   almost_full   level >= AFULL_THRESH
//   almost_empty  level <= AEMPTY_THRESH
//   level         number of stored words
//   overflow      sticky: a write was rejected because the FIFO was full
//   underflow     sticky: a read was rejected because the FIFO was empty
//   clear_errors  synchronous clear of overflow and underflow

module sync_fifo_flags #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       write_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       read_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clear_errors
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] ONE     = LW'(1);
  localparam logic [LW-1:0] FULL_LV = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LV   = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_LV   = LW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]         wr_ptr;
  logic [LW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  wr_ok;
  logic                  rd_ok;

  assign level        = level_q;
  assign full         = (level_q == FULL_LV);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_LV);
  assign almost_empty = (level_q <= AE_LV);

  // Acceptance looks only at registered flags, so a same-cycle read never
  // frees room for a write and a same-cycle write never bypasses into a read.
  // Flush wins over both requests.
  assign wr_ok = write_en && !full  && !flush;
  assign rd_ok = read_en  && !empty && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + ONE;
        2'b01:   level_q <= level_q - ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Error flags: a rejected request in the same cycle as clear_errors keeps
  // the flag set. Requests swallowed by flush are not errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full && !flush) overflow <= 1'b1;
      else if (clear_errors)          overflow <= 1'b0;
      if (read_en && empty && !flush) underflow <= 1'b1;
      else if (clear_errors)          underflow <= 1'b0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Show-ahead: head word is visible combinationally; forced to zero when
      // empty so data_out reads as 0 out of reset.
      assign data_out   = empty ? '0 : mem[rd_ptr[AW-1:0]];
      assign data_valid = !empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dvalid_q;

      // Registered read: one-cycle latency, data_out holds until the next
      // accepted read; flush only drops the valid strobe.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else if (flush) begin
          dvalid_q <= 1'b0;
        end else begin
          dvalid_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_ptr[AW-1:0]];
        end
      end

      assign data_out   = dout_q;
      assign data_valid = dvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags in both read modes
module tb_sync_fifo_flags;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          write_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          read_en = 1'b0;
  logic          clear_errors = 1'b0;

  logic [DW-1:0] data_out1, data_out0;
  logic          data_valid1, data_valid0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic [LW-1:0] level1, level0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out1), .data_valid(data_valid1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .level(level1),
    .overflow(ovf1), .underflow(unf1), .clear_errors(clear_errors)
  );

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .data_in(data_in),
    .read_en(read_en), .data_out(data_out0), .data_valid(data_valid0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .level(level0),
    .overflow(ovf0), .underflow(unf0), .clear_errors(clear_errors)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags are identical in both read modes, so every status check covers both instances.
  task automatic chk_status(input string name, input int lvl, input logic f, input logic e,
                            input logic a_f, input logic a_e, input logic ov, input logic un);
    chk({name, " level1"}, 32'(level1), 32'(lvl));
    chk({name, " level0"}, 32'(level0), 32'(lvl));
    chk({name, " flags1"}, {26'd0, full1, empty1, af1, ae1, ovf1, unf1}, {26'd0, f, e, a_f, a_e, ov, un});
    chk({name, " flags0"}, {26'd0, full0, empty0, af0, ae0, ovf0, unf0}, {26'd0, f, e, a_f, a_e, ov, un});
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    q1.push_back(d);
    q0.push_back(d);
  endtask

  // Monitor: FWFT instance delivers on an accepted read, registered instance whenever data_valid is high.
  always @(negedge clk) begin
    if (!reset) begin
      if (data_valid1 && read_en && !flush) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL fwft_data: got %0h with no word expected at %0t", data_out1, $time);
        end else begin
          logic [DW-1:0] e1;
          e1 = q1.pop_front();
          if (data_out1 !== e1) begin
            errors++;
            $display("FAIL fwft_data: got %0h expected %0h at %0t", data_out1, e1, $time);
          end
        end
      end
      if (data_valid0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL reg_data: got %0h with no word expected at %0t", data_out0, $time);
        end else begin
          logic [DW-1:0] e0;
          e0 = q0.pop_front();
          if (data_out0 !== e0) begin
            errors++;
            $display("FAIL reg_data: got %0h expected %0h at %0t", data_out0, e0, $time);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk_status("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset dv", {30'd0, data_valid1, data_valid0}, 32'd0);
    chk("reset dout", {16'd0, data_out1, data_out0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    edge_wait();

    // Fill 0x01..0x10, then a rejected 17th write
    for (int i = 1; i <= 16; i++) begin
      write_en = 1'b1;
      data_in  = DW'(i);
      push(DW'(i));
      edge_wait();
      chk_status($sformatf("fill%0d", i), i, (i == 16), 1'b0, (i >= 14), (i <= 2), 1'b0, 1'b0);
    end
    data_in = 8'hAA;
    edge_wait();
    write_en = 1'b0;
    chk_status("overflow", 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Drain, then one read too many
    for (int i = 1; i <= 16; i++) begin
      read_en = 1'b1;
      edge_wait();
      chk_status($sformatf("drain%0d", i), 16 - i, 1'b0, (i == 16), ((16 - i) >= 14), ((16 - i) <= 2), 1'b1, 1'b0);
    end
    edge_wait();
    read_en = 1'b0;
    chk_status("underflow", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    clear_errors = 1'b1;
    edge_wait();
    clear_errors = 1'b0;
    chk_status("clear1", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Registered-mode latency
    write_en = 1'b1;
    data_in  = 8'h5A;
    push(8'h5A);
    edge_wait();
    write_en = 1'b0;
    chk("lat pre dv0", {31'd0, data_valid0}, 32'd0);
    read_en = 1'b1;
    edge_wait();
    read_en = 1'b0;
    chk("lat dv0", {31'd0, data_valid0}, 32'd1);
    chk("lat dout0", 32'(data_out0), 32'h5A);
    edge_wait();
    chk("lat dv0 low", {31'd0, data_valid0}, 32'd0);
    chk("lat dout0 hold", 32'(data_out0), 32'h5A);

    // Simultaneous read/write at level 5, across pointer wrap
    for (int i = 0; i < 5; i++) begin
      write_en = 1'b1;
      data_in  = DW'(8'h20 + i);
      push(DW'(8'h20 + i));
      edge_wait();
    end
    for (int i = 0; i < 40; i++) begin
      write_en = 1'b1;
      read_en  = 1'b1;
      data_in  = DW'(8'h25 + i);
      push(DW'(8'h25 + i));
      edge_wait();
      chk($sformatf("simul level %0d", i), 32'(level1), 32'd5);
    end
    read_en = 1'b0;
    chk_status("simul end", 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Refill to full, overflow, then read down to 8
    for (int i = 0; i < 11; i++) begin
      data_in = DW'(8'h4D + i);
      push(DW'(8'h4D + i));
      edge_wait();
    end
    data_in = 8'h99;
    edge_wait();
    write_en = 1'b0;
    chk_status("overflow2", 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      read_en = 1'b1;
      edge_wait();
    end
    read_en = 1'b0;
    chk_status("pre flush", 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush with a concurrent write
    flush    = 1'b1;
    write_en = 1'b1;
    data_in  = 8'hEE;
    edge_wait();
    flush    = 1'b0;
    write_en = 1'b0;
    q1.delete();
    q0.delete();
    chk_status("flush", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("flush dv", {30'd0, data_valid1, data_valid0}, 32'd0);
    clear_errors = 1'b1;
    edge_wait();
    chk_status("clear2", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    read_en = 1'b1;
    edge_wait();
    read_en      = 1'b0;
    clear_errors = 1'b0;
    chk_status("set wins", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Async reset in the middle of a write burst
    for (int i = 0; i < 6; i++) begin
      write_en = 1'b1;
      data_in  = DW'(8'h60 + i);
      push(DW'(8'h60 + i));
      edge_wait();
    end
    data_in = 8'h66;
    chk("burst level", 32'(level1), 32'd6);
    #1;
    reset = 1'b1;
    #1;
    q1.delete();
    q0.delete();
    chk_status("async reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("async dv", {30'd0, data_valid1, data_valid0}, 32'd0);
    @(negedge clk);
    #2;
    reset   = 1'b0;
    data_in = 8'h77;
    push(8'h77);
    edge_wait();
    write_en = 1'b0;
    chk_status("resume", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    read_en = 1'b1;
    edge_wait();
    read_en = 1'b0;
    edge_wait();
    chk_status("final", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("queues drained", 32'(q1.size() + q0.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's byte FIFO and sits between the UART/command front-end and its consumers. Compared with the earlier FIFO it adds:
- programmable almost-full and almost-empty thresholds
- a level output
- sticky overflow and underflow error flags
- a synchronous flush
- a selectable read mode: first-word-fall-through (FWFT) or registered.

Parameters:
DATA_WIDTH, 8, width of each data word.
DEPTH, 16, number of entries; power of two, at least 2.
AFULL_THRESH, DEPTH-2, almost_full asserts when level >= this value; legal range 1..DEPTH.
AEMPTY_THRESH, 2, almost_empty asserts when level <= this value; legal range 0..DEPTH-1.
FWFT, 1, read mode: 1 = show-ahead, 0 = registered output with one-cycle read latency.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
flush  in  1  synchronous clear of FIFO contents.
write_en  in  1  write request.
data_in  in  DATA_WIDTH  write data.
read_en  in  1  read request.
data_out  out  DATA_WIDTH  read data.
data_valid  out  1  data_out holds a valid word.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
almost_full  out  1  level >= AFULL_THRESH.
almost_empty  out  1  level <= AEMPTY_THRESH.
level  out  $clog2(DEPTH)+1  number of stored words.
overflow  out  1  sticky flag: a write was rejected.
underflow  out  1  sticky flag: a read was rejected.
clear_errors  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset values: write pointer, read pointer and level = 0; data_out = 0; data_valid = 0; overflow = 0; underflow = 0; empty = 1; full = 0; almost_empty = 1; almost_full = 0. Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. Only the low $clog2(DEPTH) bits address the memory.
- Write acceptance: wr_ok = write_en && !full. A write when full is dropped, and overflow is set on the next edge. A simultaneous read does not make room in that same cycle.
- Read acceptance: rd_ok = read_en && !empty. A read when empty is dropped, and underflow is set. A simultaneous write does not bypass into the read.
- Level update on each edge: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither. full, empty, almost_full and almost_empty are decoded combinationally from the registered level.
- FWFT=1:
  - data_out = mem[read pointer] combinationally; data_valid = !empty.
  - A word written into an empty FIFO appears on data_out, with data_valid = 1, the cycle after the write edge.
  - rd_ok advances the pointer; the next word appears the following cycle.
  - data_out is undefined while data_valid = 0.
- FWFT=0:
  - On rd_ok, data_out <= mem[read pointer] and data_valid <= 1 at the same edge. data_valid is therefore high during the cycle after the read request, for one cycle per accepted read.
  - data_out holds its value until the next accepted read.
- Flush:
  - Synchronous; overrides read and write in the same cycle.
  - Next edge: pointers = 0, level = 0, data_valid = 0.
  - Does not change data_out in FWFT=0, the memory, or the sticky flags.
  - Requests dropped because of flush do not set the error flags.
- clear_errors clears overflow and underflow on the next edge. If an error event occurs in the same cycle, setting wins.
- Reset is asserted asynchronously and may arrive mid-operation. All state returns to its reset values immediately. There is no partial transfer: data on the edge coincident with reset is lost.
- Throughput: one write and one read per cycle sustained, including while level is at any value between 1 and DEPTH-1.

Test Plan:
- Reset then fill. Write 0x01..0x10 on consecutive cycles (DEPTH=16). Required:
  - level steps 1..16
  - almost_full rises when level = 14
  - full rises when level = 16
  - a 17th write (0xAA) sets overflow, and level stays 16.
- Drain in FWFT=1. Assert read_en for 16 cycles. Required:
  - data_out sequence 0x01..0x10, each valid in the cycle it is read
  - almost_empty rises at level 2; empty rises at level 0
  - one further read sets underflow.
- FWFT=0 latency. Write 0x5A, then read once. Required: data_valid pulses one cycle after read_en with data_out = 0x5A, then data_valid = 0 while data_out holds 0x5A.
- Simultaneous read and write. With level = 5, drive write_en and read_en together for 40 cycles with an incrementing pattern. Required:
  - level stays 5
  - output order matches input order across pointer wrap-around
  - no error flags.
- Flush and errors. With level = 8 and overflow set, assert flush together with write_en. Required:
  - next cycle level = 0, empty = 1, overflow still 1
  - clear_errors then clears overflow
  - clear_errors asserted with an empty read leaves underflow = 1.
- Async reset mid-burst. Assert reset during a write burst at level 6. Required: level = 0, empty = 1 and data_valid = 0 immediately, without waiting for a clock edge; normal operation resumes on the first edge after deassertion.
